// File: rtl/crc24_attach.sv
// Serial CRC-24A attach stage: passes a 1032/6120-bit payload through with one
// cycle of latency, then appends the 24 gCRC24A parity bits MSB-first.
module crc24_attach (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic in_start,
  input  logic in_blocksize,
  output logic data_out,
  output logic CRC_start,
  output logic CRC_blocksize,
  output logic data_valid,
  output logic CRC_end,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_t;

  localparam logic [23:0] POLY       = 24'h864CFB;
  localparam logic [12:0] P_SMALL_M1 = 13'd1031;
  localparam logic [12:0] P_LARGE_M1 = 13'd6119;
  localparam logic [12:0] CRC_M1     = 13'd23;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [23:0] crc_q, crc_d;
  logic        bs_q, bs_d;
  logic        dout_q, dout_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        end_q, end_d;
  logic        busy_q, busy_d;

  logic        fb;
  logic [23:0] crc_abs;
  logic [12:0] p_last;

  assign fb      = data_in ^ crc_q[23];
  assign crc_abs = {crc_q[22:0], 1'b0} ^ (fb ? POLY : 24'h0);
  assign p_last  = bs_q ? P_LARGE_M1 : P_SMALL_M1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    bs_d    = bs_q;
    dout_d  = 1'b0;
    start_d = 1'b0;
    valid_d = 1'b0;
    end_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          // LFSR restarts from zero, so absorbing the first bit reduces to a select.
          bs_d    = in_blocksize;
          dout_d  = data_in;
          start_d = 1'b1;
          valid_d = 1'b1;
          crc_d   = data_in ? POLY : 24'h0;
          cnt_d   = 13'd1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        dout_d  = data_in;
        valid_d = 1'b1;
        crc_d   = crc_abs;
        if (cnt_q == p_last) begin
          cnt_d   = 13'd0;
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      PARITY: begin
        dout_d  = crc_q[23];
        valid_d = 1'b1;
        crc_d   = {crc_q[22:0], 1'b0};
        if (cnt_q == CRC_M1) begin
          end_d   = 1'b1;
          cnt_d   = 13'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      bs_q    <= 1'b0;
      dout_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      bs_q    <= bs_d;
      dout_q  <= dout_d;
      start_q <= start_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out      = dout_q;
  assign CRC_start     = start_q;
  assign CRC_blocksize = bs_q;
  assign data_valid    = valid_q;
  assign CRC_end       = end_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crc24_attach.sv
// Scoreboard bench for crc24_attach: expected output stream from a polynomial
// long-division model, popped and compared by a negedge monitor.
module tb_crc24_attach;

  logic clk = 1'b0;
  logic reset, data_in, in_start, in_blocksize;
  logic data_out, CRC_start, CRC_blocksize, data_valid, CRC_end, busy;

  crc24_attach dut (
    .clk(clk), .reset(reset), .data_in(data_in), .in_start(in_start),
    .in_blocksize(in_blocksize), .data_out(data_out), .CRC_start(CRC_start),
    .CRC_blocksize(CRC_blocksize), .data_valid(data_valid), .CRC_end(CRC_end),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic d; logic s; logic e; logic bs;} item_t;

  item_t exp_q[$];
  int    exp_runs[$];
  int    checks = 0;
  int    failures = 0;
  int    run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Remainder of M(x)*x^24 divided by gCRC24A, by long division over a bit list.
  function automatic logic [23:0] crc_ref(input bit pl[$]);
    bit          m[$];
    logic [24:0] g;
    logic [23:0] r;
    int          n;
    g = 25'h1864CFB;
    m = pl;
    n = pl.size();
    for (int i = 0; i < 24; i++) m.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j <= 24; j++) m[i+j] = m[i+j] ^ g[24-j];
    for (int j = 0; j < 24; j++) r[23-j] = m[n+j];
    return r;
  endfunction

  task automatic check_all_zero(input string name);
    chk({name, "_dout"},  {31'b0, data_out},      0);
    chk({name, "_start"}, {31'b0, CRC_start},     0);
    chk({name, "_bs"},    {31'b0, CRC_blocksize}, 0);
    chk({name, "_valid"}, {31'b0, data_valid},    0);
    chk({name, "_end"},   {31'b0, CRC_end},       0);
    chk({name, "_busy"},  {31'b0, busy},          0);
  endtask

  task automatic idle(input int n, input bit check_zero);
    in_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_in = 1'($urandom_range(0, 1));
      in_blocksize = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (check_zero) check_all_zero("idle");
    end
  endtask

  // kind: 0 all-zero, 1 single 1 on last payload bit, 2 random.
  task automatic run_block(input bit bs, input int kind, input int abort_at, input int stray_at);
    bit          pl[$];
    logic [23:0] par;
    item_t       it;
    int          p;
    p = bs ? 6120 : 1032;
    for (int i = 0; i < p; i++)
      pl.push_back(kind == 2 ? 1'($urandom_range(0, 1)) : (kind == 1 && i == p - 1));
    par = crc_ref(pl);
    for (int i = 0; i < p + 24; i++) begin
      it.d  = (i < p) ? pl[i] : par[23 - (i - p)];
      it.s  = (i == 0);
      it.e  = (i == p + 23);
      it.bs = bs;
      exp_q.push_back(it);
    end
    for (int i = 0; i < p; i++) begin
      in_start     = (i == 0);
      in_blocksize = (i == 0) ? bs : 1'($urandom_range(0, 1));
      data_in      = pl[i];
      @(posedge clk); #1;
      if (i == abort_at - 1) begin
        reset = 1'b1;
        in_start = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
    end
    for (int j = 0; j < 24; j++) begin
      in_start     = (j == stray_at);
      in_blocksize = 1'($urandom_range(0, 1));
      data_in      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    item_t e;
    int    r;
    if (reset) begin
      run = 0;
    end else if (data_valid) begin
      run++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_out",      {31'b0, data_out},      {31'b0, e.d});
        chk("CRC_start",     {31'b0, CRC_start},     {31'b0, e.s});
        chk("CRC_end",       {31'b0, CRC_end},       {31'b0, e.e});
        chk("CRC_blocksize", {31'b0, CRC_blocksize}, {31'b0, e.bs});
        if (!e.e) chk("busy_in_block", {31'b0, busy}, 32'd1);
      end
    end else begin
      chk("idle_start", {31'b0, CRC_start}, 32'd0);
      chk("idle_end",   {31'b0, CRC_end},   32'd0);
      if (run != 0) begin
        if (exp_runs.size() == 0) chk("unexpected_run", run, 0);
        else begin
          r = exp_runs.pop_front();
          chk("valid_run_len", run, r);
        end
        run = 0;
      end
    end
  end

  initial begin
    reset = 1'b1; in_start = 1'b0; in_blocksize = 1'b0; data_in = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(100, 1'b1);

    exp_runs.push_back(1056); run_block(1'b0, 0, -1, -1); idle(5, 1'b0);
    exp_runs.push_back(1056); run_block(1'b0, 1, -1, -1); idle(5, 1'b0);
    exp_runs.push_back(6144); run_block(1'b1, 1, -1, -1); idle(5, 1'b0);
    exp_runs.push_back(1056); run_block(1'b0, 2, -1, -1); idle(3, 1'b0);
    exp_runs.push_back(6144); run_block(1'b1, 2, -1, -1); idle(3, 1'b0);

    exp_runs.push_back(7200);
    run_block(1'b0, 1, -1, -1);
    run_block(1'b1, 0, -1, -1);
    idle(5, 1'b0);

    run_block(1'b0, 2, 500, -1);
    idle(5, 1'b1);
    exp_runs.push_back(1056); run_block(1'b0, 0, -1, 10);
    idle(10, 1'b0);

    chk("exp_q_drained",    exp_q.size(),    0);
    chk("exp_runs_drained", exp_runs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc24_attach.md
# crc24_attach

Serial CRC-24A attachment stage that sits directly upstream of the turbo-code interleaver. It accepts a code block's payload bits one per clock, passes them through unchanged, and then appends the 24 parity bits of the LTE gCRC24A polynomial. Its output is a gap-free K-bit stream framed by `CRC_start`, `CRC_blocksize` and `CRC_end`, which the interleaver consumes directly.

## Interface
- No parameters. Block sizes are fixed: K=1056 (small) or K=6144 (large), CRC length 24.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all registers.
- `data_in` in 1: serial payload bit, sampled every cycle while payload is being accepted.
- `in_start` in 1: pulse marking the first payload bit of a block. It is valid together with that bit.
- `in_blocksize` in 1: 0 selects small (1032 payload bits), 1 selects large (6120 payload bits). Sampled only with `in_start`.
- `data_out` out 1: registered serial output, payload bits followed by parity bits.
- `CRC_start` out 1: one-cycle pulse coincident with output bit 0.
- `CRC_blocksize` out 1: latched block size. Held stable from `CRC_start` through `CRC_end`.
- `data_valid` out 1: high for exactly K consecutive cycles per block.
- `CRC_end` out 1: one-cycle pulse coincident with the last parity bit.
- `busy` out 1: high from the accept edge until the last parity bit is registered.

## Operation
- States are IDLE, PAYLOAD and PARITY. The counter `cnt` is 13 bits wide.
- In IDLE with `in_start`=1 at a rising edge:
  - latch `in_blocksize`;
  - `data_out`<=`data_in`, `CRC_start`<=1, `data_valid`<=1;
  - the LFSR absorbs the bit;
  - `cnt`<=1 and the state moves to PAYLOAD.
- In IDLE with `in_start`=0: no action.
- PAYLOAD: one bit per cycle, with no input stall. Each bit is passed to `data_out` and absorbed into the LFSR.
  - When `cnt` reaches P-1 (P=1032 or 6120), that bit is the last payload bit. The state moves to PARITY with `cnt`<=0.
- LFSR: 24 bits, initialised to 0 at every block start, MSB-first.
  - Feedback fb = `data_in` XOR crc[23].
  - crc <= {crc[22:0],0} XOR (fb ? 24'h864CFB : 0).
  - This implements gCRC24A = D^24+D^23+D^18+D^17+D^14+D^11+D^10+D^7+D^6+D^5+D^4+D^3+D+1.
- PARITY: output crc[23], then shift left by one each cycle, for 24 cycles.
  - On the 24th cycle assert `CRC_end` and return to IDLE.
- Upstream must present all P bits on consecutive cycles. The block does not check this.
- `in_start` while in PAYLOAD or PARITY is ignored. The current block completes unaffected.
- Back-to-back blocks: an `in_start` on the edge immediately after the `CRC_end` edge is accepted. The resulting output is continuous, with `data_valid` staying high and `CRC_start` immediately following `CRC_end`.
- Reset mid-block returns to IDLE. The partial block is abandoned with no `CRC_end` and no further valid output.

## Timing
- Reset values: `data_out`=0, `CRC_start`=0, `CRC_blocksize`=0, `data_valid`=0, `CRC_end`=0, `busy`=0, LFSR=0, `cnt`=0, state IDLE.
- Latency: 1 cycle from input bit to `data_out`. Let the accept edge be t:
  - output bit i appears after edge t+i, for i = 0..K-1;
  - `CRC_start` is high after edge t only;
  - the first parity bit appears after edge t+P;
  - `CRC_end` and the last parity bit appear after edge t+K-1;
  - `data_valid` falls after edge t+K unless a new block was accepted at that edge.
- Input bits are sampled at edges t..t+P-1. `data_in` is don't-care during PARITY.
- Parity bit order is crc[23] first, which matches LTE p0 transmitted first.
- Outputs are glitch-free: every output is driven directly from a flop.

## Test plan
- Reset then idle: hold `in_start`=0 for 100 cycles. All outputs stay 0 and `busy`=0.
- Small, all-zero payload: `in_start` with `in_blocksize`=0 and 1032 zeros.
  - `data_valid` is high for 1056 cycles and all output bits are 0.
  - `CRC_end` is asserted at output bit 1055.
  - `CRC_blocksize`=0 throughout.
- Small, single 1 as the last payload bit (bit 1031): the 24 parity bits are 0x864CFB MSB-first (1000 0110 0100 1100 1111 1011). The 1032 payload bits appear unchanged.
- Large, single 1 as the last payload bit: parity is 0x864CFB. `CRC_end` is asserted at output bit 6143 and `CRC_blocksize`=1 throughout.
- Back-to-back blocks: run the small last-bit-1 block, then immediately a large all-zero block.
  - `data_valid` stays continuously high for 7200 cycles.
  - `CRC_start` is asserted on the cycle after `CRC_end`.
  - Second-block parity is 0x000000, confirming the LFSR re-initialises.
- Reset mid-block, plus a stray start:
  - assert `reset` at payload bit 500; all outputs are 0 the same cycle;
  - a fresh small zero block afterwards produces correct framing;
  - an extra `in_start` pulsed during PARITY is ignored, and the block ends at bit 1055.
